// File: rtl/imem_program_encoder.sv
// Streams symbolic instruction descriptors into MIPS words and loads them into instruction memory.
// Optional feature: define ENC_MUL_EN to accept kind 3 as MUL (funct 0x1C); otherwise kind 3 is illegal.
module imem_program_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_SUB  = 4'd1;
    localparam logic [3:0] K_SLT  = 4'd2;
    localparam logic [3:0] K_MUL  = 4'd3;
    localparam logic [3:0] K_LW   = 4'd4;
    localparam logic [3:0] K_SW   = 4'd5;
    localparam logic [3:0] K_ADDI = 4'd6;
    localparam logic [3:0] K_BEQ  = 4'd7;
    localparam logic [3:0] K_J    = 4'd8;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_OVF     = 2'b10;

    localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

    state_t              state, state_n;
    logic [ADDR_W:0]     count_n;
    logic [1:0]          err_n;
    logic                we_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [31:0]         wdata_n;
    logic                legal;
    logic [31:0]         word;

    // Returns {legal, word}; every field is placed explicitly so unused input bits never reach the word.
    function automatic logic [32:0] encode(input logic [3:0]  kind,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [4:0]  rd,
                                           input logic [25:0] imm);
        logic [32:0] r;
        r = '0;
        case (kind)
            K_ADD:  r = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h20};
            K_SUB:  r = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h22};
            K_SLT:  r = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h2A};
`ifdef ENC_MUL_EN
            K_MUL:  r = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h1C};
`endif
            K_LW:   r = {1'b1, 6'h23, rs, rt, imm[15:0]};
            K_SW:   r = {1'b1, 6'h2B, rs, rt, imm[15:0]};
            K_ADDI: r = {1'b1, 6'h08, rs, rt, imm[15:0]};
            K_BEQ:  r = {1'b1, 6'h04, rs, rt, imm[15:0]};
            K_J:    r = {1'b1, 6'h02, imm};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        {legal, word} = encode(in_kind, in_rs, in_rt, in_rd, in_imm);
    end

    assign in_ready = (state == LOAD);
    assign done     = (state == DONE);
    assign cpu_hold = (state != DONE);

    always_comb begin
        state_n = state;
        count_n = count;
        err_n   = err;
        we_n    = 1'b0;
        addr_n  = imem_addr;
        wdata_n = imem_wdata;
        case (state)
            LOAD: begin
                if (in_valid) begin
                    if (!legal) begin
                        err_n   = ERR_ILLEGAL;
                        state_n = ERR;
                    end else begin
                        we_n    = 1'b1;
                        addr_n  = count[ADDR_W-1:0];
                        wdata_n = word;
                        count_n = count + 1'b1;
                        // A last word in the final slot completes normally rather than overflowing.
                        if (in_last) begin
                            state_n = DONE;
                        end else if (count == LAST_SLOT) begin
                            err_n   = ERR_OVF;
                            state_n = ERR;
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    state_n = LOAD;
                    count_n = '0;
                    err_n   = ERR_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            count      <= '0;
            err        <= ERR_NONE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            err        <= err_n;
            imem_we    <= we_n;
            imem_addr  <= addr_n;
            imem_wdata <= wdata_n;
        end
    end

endmodule

// File: tb/tb_imem_program_encoder.sv
// Directed bench for imem_program_encoder: a default-depth instance plus a 4-word instance for overflow.
module tb_imem_program_encoder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_kind = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [25:0] in_imm = '0;
    logic        in_last = 1'b0;

    logic        ready0, we0, hold0, done0;
    logic [5:0]  addr0;
    logic [31:0] wdata0;
    logic [1:0]  err0;
    logic [6:0]  count0;

    logic        ready1, we1, hold1, done1;
    logic [1:0]  addr1;
    logic [31:0] wdata1;
    logic [1:0]  err1;
    logic [2:0]  count1;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] qa0[$], qd0[$], qa1[$], qd1[$];

    always #5 CLK = ~CLK;

    imem_program_encoder u0 (
        .CLK(CLK), .RST(RST), .start(start0), .in_valid(in_valid), .in_ready(ready0),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
        .cpu_hold(hold0), .done(done0), .err(err0), .count(count0)
    );

    imem_program_encoder #(.ADDR_W(2)) u1 (
        .CLK(CLK), .RST(RST), .start(start1), .in_valid(in_valid), .in_ready(ready1),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
        .cpu_hold(hold1), .done(done1), .err(err1), .count(count1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write of that instance.
    always @(negedge CLK) begin
        if (we0 === 1'b1) begin
            check("u0_write_expected", 32'(qd0.size() != 0), 32'd1);
            if (qd0.size() != 0) begin
                check("u0_addr", 32'(addr0), qa0.pop_front());
                check("u0_wdata", wdata0, qd0.pop_front());
            end
        end
        if (we1 === 1'b1) begin
            check("u1_write_expected", 32'(qd1.size() != 0), 32'd1);
            if (qd1.size() != 0) begin
                check("u1_addr", 32'(addr1), qa1.pop_front());
                check("u1_wdata", wdata1, qd1.pop_front());
            end
        end
    end

    task automatic push0(input logic [31:0] a, input logic [31:0] d);
        qa0.push_back(a);
        qd0.push_back(d);
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] d);
        qa1.push_back(a);
        qd1.push_back(d);
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [25:0] im, input logic l);
        @(negedge CLK);
        in_valid = 1'b1;
        in_kind  = k;
        in_rs    = s;
        in_rt    = t;
        in_rd    = d;
        in_imm   = im;
        in_last  = l;
    endtask

    task automatic idle();
        @(negedge CLK);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start(input bit which);
        @(negedge CLK);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge CLK);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_in_ready"}, 32'(ready0), 32'd0);
        check({tag, "_imem_we"}, 32'(we0), 32'd0);
        check({tag, "_imem_addr"}, 32'(addr0), 32'd0);
        check({tag, "_imem_wdata"}, wdata0, 32'd0);
        check({tag, "_cpu_hold"}, 32'(hold0), 32'd1);
        check({tag, "_done"}, 32'(done0), 32'd0);
        check({tag, "_err"}, 32'(err0), 32'd0);
        check({tag, "_count"}, 32'(count0), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check_reset0("rst0");
        check("rst1_in_ready", 32'(ready1), 32'd0);
        check("rst1_cpu_hold", 32'(hold1), 32'd1);
        check("rst1_count", 32'(count1), 32'd0);
        RST = 1'b0;

        // Basic program; stray fields in unused positions must not leak into the words.
        pulse_start(1'b0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 26'h3FFFFFF, 1'b0);   push0(0, 32'h00221820);
        send(4'd4, 5'd0, 5'd8, 5'd31, 26'h3FF0004, 1'b0);  push0(1, 32'h8C080004);
        send(4'd5, 5'd29, 5'd31, 5'd7, 26'h0000008, 1'b1); push0(2, 32'hAFBF0008);
        idle();
        check("t1_count", 32'(count0), 32'd3);
        check("t1_done", 32'(done0), 32'd1);
        check("t1_cpu_hold", 32'(hold0), 32'd0);
        check("t1_in_ready", 32'(ready0), 32'd0);
        check("t1_err", 32'(err0), 32'd0);

        // Branch with oversized immediate, then jump.
        pulse_start(1'b0);
        check("t2_done_cleared", 32'(done0), 32'd0);
        check("t2_count_cleared", 32'(count0), 32'd0);
        check("t2_in_ready", 32'(ready0), 32'd1);
        send(4'd7, 5'd1, 5'd2, 5'd9, 26'h3FFFFFF, 1'b0);   push0(0, 32'h1022FFFF);
        send(4'd8, 5'd5, 5'd6, 5'd7, 26'h0000010, 1'b1);   push0(1, 32'h08000010);
        idle();
        check("t2_count", 32'(count0), 32'd2);
        check("t2_done", 32'(done0), 32'd1);

        // MUL: legal only when the optional encoding is built in.
        pulse_start(1'b0);
        send(4'd3, 5'd4, 5'd5, 5'd6, 26'h0, 1'b1);
`ifdef ENC_MUL_EN
        push0(0, 32'h0085301C);
        idle();
        check("t3_done", 32'(done0), 32'd1);
        check("t3_err", 32'(err0), 32'd0);
        check("t3_count", 32'(count0), 32'd1);
`else
        idle();
        check("t3_err", 32'(err0), 32'd1);
        check("t3_cpu_hold", 32'(hold0), 32'd1);
        check("t3_done", 32'(done0), 32'd0);
        check("t3_count", 32'(count0), 32'd0);
`endif

        // Overflow on the 4-word instance.
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            send(4'd6, 5'(i), 5'(i + 1), 5'd0, {10'h3FF, 16'h1000 + 16'(i)}, 1'b0);
            push1(i, {6'h08, 5'(i), 5'(i + 1), 16'h1000 + 16'(i)});
        end
        idle();
        check("t4_err", 32'(err1), 32'd2);
        check("t4_in_ready", 32'(ready1), 32'd0);
        check("t4_count", 32'(count1), 32'd4);
        check("t4_cpu_hold", 32'(hold1), 32'd1);
        check("t4_done", 32'(done1), 32'd0);

        // Illegal kind at position 2 (also flagged last: illegal wins).
        pulse_start(1'b0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 1'b0);  push0(0, 32'h00221820);
        send(4'd1, 5'd4, 5'd5, 5'd6, 26'h0, 1'b0);  push0(1, 32'h00853022);
        send(4'd12, 5'd1, 5'd1, 5'd1, 26'h0, 1'b1);
        idle();
        check("t5_err", 32'(err0), 32'd1);
        check("t5_count", 32'(count0), 32'd2);
        check("t5_done", 32'(done0), 32'd0);
        check("t5_in_ready", 32'(ready0), 32'd0);
        send(4'd0, 5'd9, 5'd9, 5'd9, 26'h0, 1'b1);
        idle();
        check("t5_no_accept_in_err", 32'(count0), 32'd2);
        pulse_start(1'b0);
        check("t5_err_cleared", 32'(err0), 32'd0);
        check("t5_count_cleared", 32'(count0), 32'd0);
        send(4'd6, 5'd3, 5'd7, 5'd0, 26'h3FF8000, 1'b1); push0(0, 32'h20678000);
        idle();
        check("t5_reload_done", 32'(done0), 32'd1);
        check("t5_reload_count", 32'(count0), 32'd1);

        // Reset mid-load, one cycle after the second accept.
        pulse_start(1'b0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 1'b0);  push0(0, 32'h00221820);
        send(4'd4, 5'd0, 5'd8, 5'd0, 26'h4, 1'b0);  push0(1, 32'h8C080004);
        send(4'd5, 5'd29, 5'd31, 5'd0, 26'h8, 1'b0);
        #1;
        RST = 1'b1;
        #1;
        check_reset0("t6");
        repeat (3) begin
            @(negedge CLK);
            check("t6_no_write", 32'(we0), 32'd0);
        end
        in_valid = 1'b0;
        RST = 1'b0;
        idle();
        check("t6_held", 32'(hold0), 32'd1);

        repeat (2) @(negedge CLK);
        check("q0_drained", 32'(qd0.size()), 32'd0);
        check("q1_drained", 32'(qd1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_program_encoder.md
# imem_program_encoder

Sequential instruction encoder and loader: accepts symbolic instruction descriptors (kind plus register and immediate fields) over a valid/ready stream and assembles them into 32-bit MIPS words. It writes them consecutively into instruction memory starting at address 0. It holds the single-cycle core in reset until a complete program has been written. Its encodings are exactly the inverse of the core's opcode/funct decode.

## Interface
- `ADDR_W`, default 6: instruction-memory word-address width; capacity `DEPTH = 2**ADDR_W` words.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `start` input 1: pulse; begins a new program load.
- `in_valid` input 1: descriptor valid.
- `in_ready` output 1: descriptor accepted when `in_valid & in_ready` at a rising edge.
- `in_kind` input 4: 0 ADD, 1 SUB, 2 SLT, 3 MUL, 4 LW, 5 SW, 6 ADDI, 7 BEQ, 8 J; 9–15 illegal.
- `in_rs`, `in_rt`, `in_rd` input 5 each: register fields.
- `in_imm` input 26: bits [15:0] for I-type, all 26 bits for J, ignored for R-type.
- `in_last` input 1: marks the final instruction of the program.
- `imem_we` output 1: instruction-memory write strobe.
- `imem_addr` output ADDR_W: word address.
- `imem_wdata` output 32: encoded instruction.
- `cpu_hold` output 1: holds the core in reset.
- `done` output 1: program loaded.
- `err` output 2: 01 illegal kind, 10 overflow, 00 none.
- `count` output ADDR_W+1: words written this load.

## Operation
- FSM states: IDLE, LOAD, DONE, ERR. Reset enters IDLE.
- IDLE/DONE/ERR + `start`: go to LOAD. Clear `count` and `err`, deassert `done`.
- `start` is ignored while in LOAD.
- `in_ready` = 1 only in LOAD. It is never deasserted mid-load; there is no backpressure.
- Accepted legal descriptor:
  - Registered next cycle: `imem_we`=1, `imem_addr`=`count[ADDR_W-1:0]`, `imem_wdata`=encoding.
  - `count` increments by 1.
- Encodings:
  - R-type: opcode 0, rs[25:21], rt[20:16], rd[15:11], shamt 0. Funct: ADD 0x20, SUB 0x22, SLT 0x2A, MUL 0x1C.
  - I-type: opcode[31:26], rs[25:21], rt[20:16], imm[15:0]. Opcodes: LW 0x23, SW 0x2B, ADDI 0x08, BEQ 0x04.
  - J: opcode 0x02, `in_imm[25:0]`.
  - Unused field bits are never leaked into the word.
- Accepted `in_last` (legal): the word is written, then the FSM enters DONE.
- Accepted illegal kind: no write, `count` unchanged, `err`=01, FSM enters ERR.
- Overflow: a legal non-last word accepted at `count == DEPTH-1` is written into the last slot, then `err`=10 and FSM enters ERR. No address wrap ever occurs.
- Illegal kind together with `in_last`: illegal takes priority (err=01).
- `cpu_hold` = 0 only in DONE; it is 1 in IDLE, LOAD, and ERR.

## Timing
- Reset values: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=1, `done`=0, `err`=00, `count`=0.
- Latency: accept edge k produces `imem_we` high during cycle k+1, for exactly 1 cycle per accepted word.
- Throughput: 1 word/cycle.
- `done`, `cpu_hold`, `err`, and `in_ready` all update at the same edge that registers the final write or error. `in_ready` falls that edge, so no descriptor is accepted in the last-word/error cycle+1.
- `RST` mid-load: immediately returns all outputs to reset values. Partially written memory is not cleared; the core remains held.

## Configuration
- `ENC_MUL_EN` defined: kind 3 encodes MUL (funct 0x1C).
- `ENC_MUL_EN` undefined: kind 3 is illegal (err=01, no write), identical to kinds 9–15.

## Test plan
- Reset, then `start`, then stream ADD rs1 rt2 rd3; LW rs0 rt8 imm4; SW rs29 rt31 imm8 (last).
  - Required writes: addr 0 = 0x00221820, addr 1 = 0x8C080004, addr 2 = 0xAFBF0008.
  - Then `count`=3, `done`=1, `cpu_hold`=0.
- BEQ rs1 rt2 imm 0x3FFFFFF, then J imm 0x0000010 (last).
  - Required writes: 0x1022FFFF, then 0x08000010 (upper imm bits masked for BEQ).
- MUL rs4 rt5 rd6 (last).
  - With `ENC_MUL_EN`: write 0x0085301C.
  - Without `ENC_MUL_EN`: no write, `err`=01, `cpu_hold`=1.
- ADDR_W=2: stream 4 non-last ADDI words.
  - Required: 4 writes at addr 0..3, then `err`=10, `in_ready`=0, `count`=4.
- Illegal kind 12 at position 2: 2 writes only, `err`=01.
  - A subsequent `start` clears `err` and loads again from addr 0.
- Assert `RST` one cycle after the 2nd accept.
  - Required: all outputs at reset values asynchronously, no further writes.
